fp_regfile_sb: RTL and testbench

Parametrised floating-point register file with per-register busy scoreboard, NaN-boxing for single-precision traffic and optional write-to-read bypass. It sits between FPU issue and writeback and replaces the fixed 32x64, 3-read-port FP register file. Writes are never dropped on address collision; collisions are resolved by the bypass rule instead.

---
 rtl/fp_regfile_sb.sv | 92 +++++++++
 tb/tb_fp_regfile_sb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_regfile_sb.sv
// rtl/fp_regfile_sb.sv - FP register file with busy scoreboard, NaN-boxing and optional bypass
// Define FP_REGFILE_BYPASS_EN to forward same-cycle writeback data/busy-clear to read ports.
module fp_regfile_sb #(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  parameter  int NREAD = 3,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  wsingle,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  input  logic [NREAD*AW-1:0]   raddr,
  input  logic [NREAD-1:0]      rsingle,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  output logic [CW-1:0]         busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [XLEN-1:0]  wval;
  logic             set_evt;
  logic             clr_evt;

  // Single-precision writebacks are stored already boxed so reads only need the check.
  if (XLEN == 64) begin : g_wbox64
    assign wval = wsingle ? {32'hFFFF_FFFF, wdata[31:0]} : wdata;
  end else begin : g_wbox32
    logic unused_single;
    assign wval          = wdata;
    assign unused_single = ^{wsingle, rsingle};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[waddr] <= wval;
    end
  end

  // Issue wins over writeback on the same address, so a new producer is never lost.
  always_comb begin
    set_evt = iss_valid && !busy[iss_addr];
    clr_evt = wen && busy[waddr] && !(iss_valid && (iss_addr == waddr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wen)       busy[waddr]    <= 1'b0;
      if (iss_valid) busy[iss_addr] <= 1'b1;
      if (set_evt && !clr_evt && (busy_cnt != CW'(NREGS)))
        busy_cnt <= busy_cnt + CW'(1);
      else if (clr_evt && !set_evt && (busy_cnt != '0))
        busy_cnt <= busy_cnt - CW'(1);
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] sel;

    assign ra = raddr[p*AW +: AW];

`ifdef FP_REGFILE_BYPASS_EN
    logic hit;
    assign hit      = wen && (waddr == ra);
    assign sel      = hit ? wval : regs[ra];
    assign rbusy[p] = hit ? (iss_valid && (iss_addr == ra)) : busy[ra];
`else
    assign sel      = regs[ra];
    assign rbusy[p] = busy[ra];
`endif

    if (XLEN == 64) begin : g_unbox64
      assign rdata[p*XLEN +: XLEN] =
        (rsingle[p] && (sel[63:32] != 32'hFFFF_FFFF)) ? 64'hFFFF_FFFF_7FC0_0000 : sel;
    end else begin : g_raw32
      assign rdata[p*XLEN +: XLEN] = sel;
    end
  end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// tb/tb_fp_regfile_sb.sv - directed vector bench for fp_regfile_sb (64x32x3 and 32x16x2 instances)
module tb_fp_regfile_sb;

  localparam logic [63:0] QNAN = 64'hFFFF_FFFF_7FC0_0000;
  localparam logic [63:0] PI   = 64'h4009_21FB_5444_2D18;
`ifdef FP_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  always #5 clk = ~clk;

  logic         wen, wsingle, iss_valid;
  logic [4:0]   waddr, iss_addr;
  logic [63:0]  wdata;
  logic [14:0]  raddr;
  logic [2:0]   rsingle;
  logic [191:0] rdata;
  logic [2:0]   rbusy;
  logic [5:0]   busy_cnt;

  logic         s_wen, s_wsingle, s_iss_valid;
  logic [3:0]   s_waddr, s_iss_addr;
  logic [31:0]  s_wdata;
  logic [7:0]   s_raddr;
  logic [1:0]   s_rsingle;
  logic [63:0]  s_rdata;
  logic [1:0]   s_rbusy;
  logic [4:0]   s_busy_cnt;

  fp_regfile_sb #(.XLEN(64), .NREGS(32), .NREAD(3)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wsingle(wsingle),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .raddr(raddr), .rsingle(rsingle),
    .rdata(rdata), .rbusy(rbusy), .busy_cnt(busy_cnt)
  );

  fp_regfile_sb #(.XLEN(32), .NREGS(16), .NREAD(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .wen(s_wen), .waddr(s_waddr), .wdata(s_wdata), .wsingle(s_wsingle),
    .iss_valid(s_iss_valid), .iss_addr(s_iss_addr), .raddr(s_raddr), .rsingle(s_rsingle),
    .rdata(s_rdata), .rbusy(s_rbusy), .busy_cnt(s_busy_cnt)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        wsingle;
    logic        iss;
    logic [4:0]  iss_addr;
    logic [4:0]  ra;
    logic        rs;
    logic [63:0] e_data;
    logic        e_busy;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [4:0] wa, input logic [63:0] wd, input logic ws,
                     input logic iv, input logic [4:0] ia, input logic [4:0] ra, input logic rs,
                     input logic [63:0] ed, input logic eb, input logic [5:0] ec);
    vec_t v;
    v.wen = w; v.waddr = wa; v.wdata = wd; v.wsingle = ws; v.iss = iv; v.iss_addr = ia;
    v.ra = ra; v.rs = rs; v.e_data = ed; v.e_busy = eb; v.e_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic idle();
    wen = 1'b0; wsingle = 1'b0; iss_valid = 1'b0; waddr = '0; iss_addr = '0; wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    raddr = '0; rsingle = 3'b010;
    s_wen = 1'b0; s_wsingle = 1'b0; s_iss_valid = 1'b0; s_waddr = '0; s_iss_addr = '0;
    s_wdata = '0; s_raddr = '0; s_rsingle = '0;
    step(); step();
    chk("reset rdata0", rdata[63:0], 64'd0);
    chk("reset rdata1 single", rdata[127:64], QNAN);
    chk("reset rbusy", {61'd0, rbusy}, 64'd0);
    chk("reset busy_cnt", {58'd0, busy_cnt}, 64'd0);
    rst_n = 1'b1;
    step();

    //    wen waddr  wdata                    ws  iss ia     ra     rs  e_data                   eb  cnt
    add(0, 5'd0, 64'd0,                      0, 0, 5'd0,  5'd0,  0, 64'd0,                     0, 6'd0);
    add(0, 5'd0, 64'd0,                      0, 0, 5'd0,  5'd0,  1, QNAN,                      0, 6'd0);
    add(1, 5'd7, PI,                         0, 0, 5'd0,  5'd0,  0, 64'd0,                     0, 6'd0);
    add(0, 5'd0, 64'd0,                      0, 0, 5'd0,  5'd7,  0, PI,                        0, 6'd0);
    add(1, 5'd2, 64'h1234_5678_3F80_0000,    1, 0, 5'd0,  5'd7,  1, QNAN,                      0, 6'd0);
    add(0, 5'd0, 64'd0,                      0, 0, 5'd0,  5'd2,  1, 64'hFFFF_FFFF_3F80_0000,   0, 6'd0);
    add(0, 5'd0, 64'd0,                      0, 0, 5'd0,  5'd2,  0, 64'hFFFF_FFFF_3F80_0000,   0, 6'd0);
    add(1, 5'd1, 64'h3FF0_0000_0000_0000,    0, 1, 5'd3,  5'd2,  0, 64'hFFFF_FFFF_3F80_0000,   0, 6'd0);
    add(0, 5'd0, 64'd0,                      0, 1, 5'd4,  5'd1,  1, QNAN,                      0, 6'd1);
    add(0, 5'd0, 64'd0,                      0, 1, 5'd4,  5'd3,  0, 64'd0,                     1, 6'd2);
    add(1, 5'd3, 64'hAAAA_AAAA_AAAA_AAAA,    0, 1, 5'd3,  5'd4,  0, 64'd0,                     1, 6'd2);
    add(1, 5'd9, 64'h99,                     0, 0, 5'd0,  5'd3,  0, 64'hAAAA_AAAA_AAAA_AAAA,   1, 6'd2);
    add(1, 5'd4, 64'h44,                     0, 0, 5'd0,  5'd9,  0, 64'h99,                    0, 6'd2);
    add(1, 5'd3, 64'h33,                     0, 0, 5'd0,  5'd4,  0, 64'h44,                    0, 6'd1);
    add(0, 5'd0, 64'd0,                      0, 0, 5'd0,  5'd3,  0, 64'h33,                    0, 6'd0);

    foreach (vq[i]) begin
      wen = vq[i].wen; waddr = vq[i].waddr; wdata = vq[i].wdata; wsingle = vq[i].wsingle;
      iss_valid = vq[i].iss; iss_addr = vq[i].iss_addr;
      raddr = {3{vq[i].ra}}; rsingle = {3{vq[i].rs}};
      #2;
      chk($sformatf("vec%0d rdata0", i), rdata[63:0], vq[i].e_data);
      chk($sformatf("vec%0d rbusy0", i), {63'd0, rbusy[0]}, {63'd0, vq[i].e_busy});
      chk($sformatf("vec%0d busy_cnt", i), {58'd0, busy_cnt}, {58'd0, vq[i].e_cnt});
      step();
    end

    // All ports on one register, each with its own rsingle.
    idle(); raddr = {3{5'd7}}; rsingle = 3'b010;
    #2;
    chk("multi rdata0", rdata[63:0], PI);
    chk("multi rdata1 single", rdata[127:64], QNAN);
    chk("multi rdata2", rdata[191:128], PI);
    step();

    // Same-cycle write while reading the target register.
    raddr = '0; rsingle = '0;
    wen = 1'b1; waddr = 5'd5; wdata = 64'd1; iss_valid = 1'b1; iss_addr = 5'd5;
    step();
    idle(); wen = 1'b1; waddr = 5'd5; wdata = 64'd2; raddr[4:0] = 5'd5;
    #2;
    chk("bypass rdata0", rdata[63:0], BYP ? 64'd2 : 64'd1);
    chk("bypass rbusy0", {63'd0, rbusy[0]}, {63'd0, !BYP});
    chk("bypass cnt", {58'd0, busy_cnt}, 64'd1);
    step();
    idle();
    #2;
    chk("after write rdata0", rdata[63:0], 64'd2);
    chk("after write rbusy0", {63'd0, rbusy[0]}, 64'd0);
    chk("after write cnt", {58'd0, busy_cnt}, 64'd0);
    iss_valid = 1'b1; iss_addr = 5'd6;
    step();
    wen = 1'b1; waddr = 5'd6; wdata = 64'h66; iss_valid = 1'b1; iss_addr = 5'd6; raddr[4:0] = 5'd6;
    #2;
    chk("bypass reissue rbusy0", {63'd0, rbusy[0]}, 64'd1);
    chk("bypass reissue rdata0", rdata[63:0], BYP ? 64'h66 : 64'd0);
    step();
    idle();
    #2;
    chk("reissue rbusy0", {63'd0, rbusy[0]}, 64'd1);
    chk("reissue rdata0", rdata[63:0], 64'h66);
    chk("reissue cnt", {58'd0, busy_cnt}, 64'd1);
    wen = 1'b1; waddr = 5'd6;  wdata = 64'h66;
    step();

    // Reset mid-stream with five busy registers.
    idle();
    for (int a = 10; a < 15; a++) begin
      iss_valid = 1'b1; iss_addr = 5'(a);
      step();
    end
    idle();
    raddr = {5'd10, 5'd7, 5'd7}; rsingle = 3'b010;
    #2;
    chk("pre-reset cnt", {58'd0, busy_cnt}, 64'd5);
    chk("pre-reset rbusy2", {63'd0, rbusy[2]}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset rdata0", rdata[63:0], 64'd0);
    chk("async reset rdata1 single", rdata[127:64], QNAN);
    chk("async reset rbusy2", {63'd0, rbusy[2]}, 64'd0);
    chk("async reset cnt", {58'd0, busy_cnt}, 64'd0);
    wen = 1'b1; waddr = 5'd8; wdata = 64'hDEAD; iss_valid = 1'b1; iss_addr = 5'd8;
    step();
    idle(); raddr = {5'd0, 5'd0, 5'd8}; rsingle = '0;
    #1 rst_n = 1'b1;
    #1;
    chk("write in reset lost", rdata[63:0], 64'd0);
    chk("issue in reset lost", {58'd0, busy_cnt}, 64'd0);
    wen = 1'b1; waddr = 5'd8; wdata = 64'hBEEF; iss_valid = 1'b1; iss_addr = 5'd9;
    step();
    idle(); raddr = {5'd0, 5'd9, 5'd8};
    #2;
    chk("first edge write", rdata[63:0], 64'hBEEF);
    chk("first edge issue rbusy1", {63'd0, rbusy[1]}, 64'd1);
    chk("first edge cnt", {58'd0, busy_cnt}, 64'd1);

    // 32-bit, 16-register, 2-port build: saturating count and ignored single flags.
    for (int a = 0; a < 16; a++) begin
      s_iss_valid = 1'b1; s_iss_addr = 4'(a);
      step();
    end
    s_iss_valid = 1'b1; s_iss_addr = 4'd0; s_raddr = {4'd15, 4'd0};
    #2;
    chk("s full cnt", {59'd0, s_busy_cnt}, 64'd16);
    chk("s rbusy1", {63'd0, s_rbusy[1]}, 64'd1);
    step();
    s_iss_valid = 1'b0;
    #2;
    chk("s no wrap cnt", {59'd0, s_busy_cnt}, 64'd16);
    s_wen = 1'b1; s_waddr = 4'd2; s_wdata = 32'h3F80_0000; s_wsingle = 1'b1;
    step();
    s_waddr = 4'd3; s_wdata = 32'h1234_5678;
    step();
    s_wen = 1'b0; s_wsingle = 1'b0; s_raddr = {4'd3, 4'd2}; s_rsingle = 2'b11;
    #2;
    chk("s single rdata0", {32'd0, s_rdata[31:0]}, 64'h3F80_0000);
    chk("s single rdata1", {32'd0, s_rdata[63:32]}, 64'h1234_5678);
    chk("s cleared rbusy", {62'd0, s_rbusy}, 64'd0);
    chk("s cnt after clears", {59'd0, s_busy_cnt}, 64'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
